v_state_table: RTL and testbench
================================

Name: v_state_table

Overview:
- Storage responder for the per-list state interface driven by the update pipeline.
- Accepts one read request and one write request per cycle; returns registered read data one cycle later.
- Write-first bypass when a read and a write target the same entry in the same cycle.
- After reset, a sequencer zero-initialises every entry before normal service begins.

Parameters:
- ENTRIES, 16, number of state entries (any value >= 2, not required to be a power of two).
- STATE_W, 32, width of one state word in bits.
- ADDR_W, $clog2(ENTRIES), address width in bits.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- i_state_ren  input  1  read request.
- i_state_raddr  input  ADDR_W  read address.
- o_state_rdata_r  output  STATE_W  registered read data.
- o_state_rvld_r  output  1  read data valid, one cycle after accepted i_state_ren.
- i_state_wen  input  1  write request.
- i_state_waddr  input  ADDR_W  write address.
- i_state_wdata  input  STATE_W  write data.
- o_init_done_r  output  1  high once initialisation completes; low during init.
- o_err_r  output  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Reset values (rst high at a posedge):
  - o_state_rdata_r = 0, o_state_rvld_r = 0, o_init_done_r = 0, o_err_r = 0.
  - FSM enters INIT; init counter = 0.
- FSM INIT:
  - Each cycle writes 0 to entry[counter], then counter += 1.
  - When counter == ENTRIES-1 is written, move to READY and set o_init_done_r = 1 on the same edge.
  - INIT lasts exactly ENTRIES cycles after rst deasserts.
- FSM READY: terminal state; left only by rst.
- Requests during INIT:
  - i_state_wen is dropped; no storage change.
  - i_state_ren gives o_state_rvld_r = 1 next cycle with o_state_rdata_r = 0.
  - o_err_r is not raised for either.
- Read, READY:
  - i_state_ren at cycle N gives o_state_rvld_r = 1 and o_state_rdata_r = entry value at cycle N+1.
  - Latency is fixed at 1 cycle.
  - No ren means o_state_rvld_r = 0; o_state_rdata_r holds its last value.
- Write, READY: i_state_wen at cycle N updates the entry at the end of cycle N. A read issued at N+1 returns the new value.
- Same-cycle read and write, same address: read returns i_state_wdata (write-first bypass).
- Same-cycle read and write, different addresses: both proceed independently.
- Out-of-range address (>= ENTRIES; reachable only when ENTRIES is not a power of two):
  - Read returns 0 with rvld = 1.
  - Write is dropped.
  - o_err_r pulses 1 for one cycle, the cycle after the request.
  - Simultaneous bad read and bad write produce a single pulse.
- No backpressure: every request is accepted in the cycle presented.
- rst mid-INIT or mid-READY:
  - Restarts INIT from counter 0.
  - In-flight read is discarded (rvld = 0 after reset).
  - All entries are re-zeroed.
- Storage: a flop array of ENTRIES x STATE_W, not reset directly; cleared only by the INIT sequencer.

Test Plan:
- Init timing, ENTRIES=16: assert rst 1 cycle, release → o_init_done_r low 16 cycles, rises on 16th edge. ren addr 5 during INIT → rvld=1, rdata=0.
- Write/read latency: in READY, write addr 3 = 0xDEADBEEF at N; ren addr 3 at N+1 → rvld=1, rdata=0xDEADBEEF at N+2. ren addr 4 → rdata=0.
- Bypass: entry 7 holds 0x11; same cycle wen addr 7 = 0x22 and ren addr 7 → next-cycle rdata=0x22. Later read of 7 → 0x22.
- Out-of-range, ENTRIES=12: wen addr 13 = 0x55 and ren addr 13 in same cycle → next cycle rdata=0, rvld=1, o_err_r=1 for exactly one cycle. Reads of all 12 valid entries unchanged.
- Back-to-back streaming: ren addrs 0,1,2,3 on consecutive cycles after writing 0xA0..0xA3 → rdata 0xA0..0xA3 on consecutive cycles, rvld continuously high 4 cycles.
- Reset mid-operation: write 0xFF to all entries, assert rst during an outstanding read → rvld=0 next cycle, init repeats for ENTRIES cycles, then every entry reads 0.

Source files
------------

// File: rtl/v_state_table.sv
// Per-list state storage responder: one read and one write per cycle,
// registered read data, write-first bypass and zero-initialise after reset.
module v_state_table #(
  parameter int ENTRIES = 16,
  parameter int STATE_W = 32,
  parameter int ADDR_W  = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_state_ren,
  input  logic [ADDR_W-1:0]  i_state_raddr,
  output logic [STATE_W-1:0] o_state_rdata_r,
  output logic               o_state_rvld_r,
  input  logic               i_state_wen,
  input  logic [ADDR_W-1:0]  i_state_waddr,
  input  logic [STATE_W-1:0] i_state_wdata,
  output logic               o_init_done_r,
  output logic               o_err_r
);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);
  localparam logic [ADDR_W:0]   LIM  = (ADDR_W + 1)'(ENTRIES);

  state_e state_q, state_d;

  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [STATE_W-1:0] rdata_q, rdata_d;
  logic               rvld_q, rvld_d;
  logic               done_q;
  logic               err_q, err_d;

  logic [STATE_W-1:0] mem_q [ENTRIES];

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_wa;
  logic [STATE_W-1:0] mem_wd;

  logic r_ok, w_ok;

  // Addresses past ENTRIES-1 only exist when ENTRIES is not a power of two.
  assign r_ok = {1'b0, i_state_raddr} < LIM;
  assign w_ok = {1'b0, i_state_waddr} < LIM;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = cnt_q;
    mem_wd  = '0;
    unique case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_READY;
          cnt_d   = '0;
        end
        if (i_state_ren) begin
          rvld_d  = 1'b1;
          rdata_d = '0;
        end
      end
      S_READY: begin
        if (i_state_wen && w_ok) begin
          mem_we = 1'b1;
          mem_wa = i_state_waddr;
          mem_wd = i_state_wdata;
        end
        if (i_state_ren) begin
          rvld_d = 1'b1;
          if (!r_ok)
            rdata_d = '0;
          else if (i_state_wen && i_state_waddr == i_state_raddr)
            rdata_d = i_state_wdata;
          else
            rdata_d = mem_q[i_state_raddr];
        end
        err_d = (i_state_ren && !r_ok) || (i_state_wen && !w_ok);
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      done_q  <= (state_d == S_READY);
      err_q   <= err_d;
    end
  end

  // Storage is cleared only by the init sequencer.
  always_ff @(posedge clk) begin
    if (!rst && mem_we)
      mem_q[mem_wa] <= mem_wd;
  end

  assign o_state_rdata_r = rdata_q;
  assign o_state_rvld_r  = rvld_q;
  assign o_init_done_r   = done_q;
  assign o_err_r         = err_q;

endmodule

// File: tb/tb_v_state_table.sv
// Directed bench for v_state_table: a 16-entry instance and a
// 12-entry instance for out-of-range addressing.
module tb_v_state_table;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        a_ren, a_wen, a_vld, a_done, a_err;
  logic [3:0]  a_raddr, a_waddr;
  logic [31:0] a_wdata, a_rdata;

  logic        b_ren, b_wen, b_vld, b_done, b_err;
  logic [3:0]  b_raddr, b_waddr;
  logic [31:0] b_wdata, b_rdata;

  int vectors = 0;
  int miscompares = 0;

  v_state_table #(.ENTRIES(16), .STATE_W(32)) dut_a (
    .clk             (clk),
    .rst             (rst),
    .i_state_ren     (a_ren),
    .i_state_raddr   (a_raddr),
    .o_state_rdata_r (a_rdata),
    .o_state_rvld_r  (a_vld),
    .i_state_wen     (a_wen),
    .i_state_waddr   (a_waddr),
    .i_state_wdata   (a_wdata),
    .o_init_done_r   (a_done),
    .o_err_r         (a_err)
  );

  v_state_table #(.ENTRIES(12), .STATE_W(32)) dut_b (
    .clk             (clk),
    .rst             (rst),
    .i_state_ren     (b_ren),
    .i_state_raddr   (b_raddr),
    .o_state_rdata_r (b_rdata),
    .o_state_rvld_r  (b_vld),
    .i_state_wen     (b_wen),
    .i_state_waddr   (b_waddr),
    .i_state_wdata   (b_wdata),
    .o_init_done_r   (b_done),
    .o_err_r         (b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_ren = 0; a_wen = 0; a_raddr = 0; a_waddr = 0; a_wdata = 0;
    b_ren = 0; b_wen = 0; b_raddr = 0; b_waddr = 0; b_wdata = 0;

    // reset state
    tick();
    chk("rst_rvld", 32'(a_vld), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_rdata", a_rdata, 0);

    // init timing, read during init
    rst = 1'b0;
    a_ren = 1; a_raddr = 4'd5;
    a_wen = 1; a_waddr = 4'd5; a_wdata = 32'h1234_5678;
    tick();
    chk("init_rvld", 32'(a_vld), 1);
    chk("init_rdata", a_rdata, 0);
    chk("init_err", 32'(a_err), 0);
    chk("init_done1", 32'(a_done), 0);
    a_ren = 0; a_wen = 0;
    for (int i = 2; i <= 16; i++) begin
      tick();
      chk("init_done_a", 32'(a_done), (i == 16) ? 1 : 0);
      chk("init_done_b", 32'(b_done), (i >= 12) ? 1 : 0);
    end

    // write dropped during init: entry 5 still zero
    a_ren = 1; a_raddr = 4'd5;
    tick();
    chk("init_wdrop", a_rdata, 0);
    a_ren = 0;

    // write then read latency
    a_wen = 1; a_waddr = 4'd3; a_wdata = 32'hDEAD_BEEF;
    tick();
    a_wen = 0;
    a_ren = 1; a_raddr = 4'd3;
    tick();
    chk("wr_rd_vld", 32'(a_vld), 1);
    chk("wr_rd_data", a_rdata, 32'hDEAD_BEEF);
    a_raddr = 4'd4;
    tick();
    chk("rd4_data", a_rdata, 0);
    a_ren = 0;
    tick();
    chk("idle_vld", 32'(a_vld), 0);
    chk("idle_hold", a_rdata, 0);

    // bypass
    a_wen = 1; a_waddr = 4'd7; a_wdata = 32'h11;
    tick();
    a_wdata = 32'h22; a_ren = 1; a_raddr = 4'd7;
    tick();
    chk("bypass", a_rdata, 32'h22);
    a_waddr = 4'd8; a_wdata = 32'h33;
    tick();
    chk("diff_addr_rd", a_rdata, 32'h22);
    a_wen = 0; a_raddr = 4'd8;
    tick();
    chk("diff_addr_wr", a_rdata, 32'h33);
    a_ren = 0;

    // streaming
    for (int i = 0; i < 4; i++) begin
      a_wen = 1; a_waddr = 4'(i); a_wdata = 32'hA0 + 32'(i);
      tick();
    end
    a_wen = 0;
    a_ren = 1; a_raddr = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_vld", 32'(a_vld), 1);
      chk("stream_data", a_rdata, 32'hA0 + 32'(i));
      a_raddr = 4'(i + 1);
    end
    a_ren = 0;

    // out-of-range on 12-entry instance
    for (int i = 0; i < 12; i++) begin
      b_wen = 1; b_waddr = 4'(i); b_wdata = 32'h100 + 32'(i);
      tick();
    end
    chk("oor_pre_err", 32'(b_err), 0);
    b_waddr = 4'd13; b_wdata = 32'h55;
    b_ren = 1; b_raddr = 4'd13;
    tick();
    chk("oor_vld", 32'(b_vld), 1);
    chk("oor_rdata", b_rdata, 0);
    chk("oor_err", 32'(b_err), 1);
    b_wen = 0; b_ren = 0;
    tick();
    chk("oor_err_pulse", 32'(b_err), 0);
    b_ren = 1; b_raddr = 4'd0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("oor_keep", b_rdata, 32'h100 + 32'(i));
      b_raddr = 4'(i + 1);
    end
    b_ren = 0;
    tick();
    chk("oor_valid_err", 32'(b_err), 0);

    // reset mid-operation
    for (int i = 0; i < 16; i++) begin
      a_wen = 1; a_waddr = 4'(i); a_wdata = 32'hFF;
      tick();
    end
    a_wen = 0;
    a_ren = 1; a_raddr = 4'd2;
    rst = 1'b1;
    tick();
    chk("mid_rst_vld", 32'(a_vld), 0);
    chk("mid_rst_done", 32'(a_done), 0);
    rst = 1'b0; a_ren = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("reinit_done", 32'(a_done), (i == 16) ? 1 : 0);
    end
    a_ren = 1; a_raddr = 4'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("rezero_vld", 32'(a_vld), 1);
      chk("rezero_data", a_rdata, 0);
      a_raddr = 4'(i + 1);
    end
    a_ren = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
